// File: rtl/telegraph_pkg.sv
// Shared types and parameter checks for the telegraph frame receiver.
package telegraph_pkg;

   typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, PARITY} rx_state_t;

   localparam logic [15:0] DEFAULT_FLAG = 16'h007E;

   function automatic bit flag_params_ok(input int unsigned flag_w, input logic [15:0] flag);
      return (flag_w >= 2) && (flag_w <= 16) && (flag != '0);
   endfunction

endpackage

// File: rtl/telegraph_frame_rx_if.sv
// Serial-side and result signals of the telegraph frame receiver.
interface telegraph_frame_rx_if #(
   parameter int unsigned CNT_W = 4
);
   logic             ClkEn;
   logic             SerIn;
   logic             SerOut;
   logic             SerOutValid;
   logic             FrameDone;
   logic             FrameErr;
   logic [CNT_W-1:0] CntOut;

   modport master (
      output ClkEn, SerIn,
      input  SerOut, SerOutValid, FrameDone, FrameErr, CntOut
   );

   modport slave (
      input  ClkEn, SerIn,
      output SerOut, SerOutValid, FrameDone, FrameErr, CntOut
   );
endinterface

// File: rtl/telegraph_flag_det.sv
// Sliding-window start-flag detector; match looks at the window after this sample.
module telegraph_flag_det
   import telegraph_pkg::*;
#(
   parameter int unsigned         FLAG_W = 8,
   parameter logic [FLAG_W-1:0]   FLAG   = FLAG_W'(DEFAULT_FLAG)
) (
   input  logic Clk,
   input  logic Rst,
   input  logic ClkEn,
   input  logic SerIn,
   input  logic clr,
   output logic match
);
   logic [FLAG_W-1:0] window;
   logic [FLAG_W-1:0] window_next;

   assign window_next = {window[FLAG_W-2:0], SerIn};
   assign match       = ClkEn && (window_next == FLAG);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         window <= '0;
      end else if (clr) begin
         window <= '0;
      end else if (ClkEn) begin
         window <= window_next;
      end
   end

   if (!flag_params_ok(FLAG_W, 16'(FLAG))) begin : g_bad_params
      $error("telegraph_flag_det: FLAG_W must be 2..16 and FLAG non-zero");
   end
endmodule

// File: rtl/telegraph_frame_rx.sv
// Telegraph frame receiver: flag hunt, length field, payload forward, even parity, good-frame count.
module telegraph_frame_rx
   import telegraph_pkg::*;
#(
   parameter int unsigned       FLAG_W    = 8,
   parameter logic [FLAG_W-1:0] FLAG      = FLAG_W'(DEFAULT_FLAG),
   parameter int unsigned       LEN_W     = 4,
   parameter bit                PARITY_EN = 1'b1,
   parameter int unsigned       CNT_W     = 4
) (
   input  logic                Clk,
   input  logic                Rst,
   telegraph_frame_rx_if.slave bus
);
   localparam int unsigned LC_W = $clog2(LEN_W + 1);

   rx_state_t        state;
   logic [LEN_W-1:0] len_reg;
   logic [LEN_W-1:0] len_shift;
   logic [LEN_W-1:0] bit_cnt;
   logic [LC_W-1:0]  len_cnt;
   logic             par_acc;
   logic             ser_out;
   logic             out_valid;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] cnt;
   logic             hunt_en;
   logic             match;
   logic             last_len;
   logic             last_bit;
   logic             frame_end;
   logic             frame_bad;

   assign len_shift = LEN_W'({len_reg, bus.SerIn});
   assign last_len  = (len_cnt == LC_W'(LEN_W - 1));
   assign last_bit  = (bit_cnt == len_reg - LEN_W'(1));
   assign hunt_en   = bus.ClkEn && (state == HUNT);

   always_comb begin
      frame_end = 1'b0;
      frame_bad = 1'b0;
      if (bus.ClkEn) begin
         case (state)
            LEN:     frame_end = last_len && (len_shift == '0) && !PARITY_EN;
            PAYLOAD: frame_end = last_bit && !PARITY_EN;
            PARITY: begin
               frame_end = 1'b1;
               frame_bad = (bus.SerIn != par_acc);
            end
            default: ;
         endcase
      end
   end

   telegraph_flag_det #(
      .FLAG_W (FLAG_W),
      .FLAG   (FLAG)
   ) u_flag_det (
      .Clk   (Clk),
      .Rst   (Rst),
      .ClkEn (hunt_en),
      .SerIn (bus.SerIn),
      .clr   (match || frame_end),
      .match (match)
   );

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state     <= HUNT;
         len_reg   <= '0;
         len_cnt   <= '0;
         bit_cnt   <= '0;
         par_acc   <= 1'b0;
         ser_out   <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         cnt       <= '0;
      end else begin
         out_valid <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         if (bus.ClkEn) begin
            case (state)
               HUNT: if (match) state <= LEN;
               LEN: begin
                  len_reg <= len_shift;
                  if (last_len) begin
                     len_cnt <= '0;
                     state   <= (len_shift != '0) ? PAYLOAD : PARITY;
                  end else begin
                     len_cnt <= len_cnt + LC_W'(1);
                  end
               end
               PAYLOAD: begin
                  ser_out   <= bus.SerIn;
                  out_valid <= 1'b1;
                  par_acc   <= par_acc ^ bus.SerIn;
                  if (last_bit) state <= PARITY;
                  else          bit_cnt <= bit_cnt + LEN_W'(1);
               end
               default: ;
            endcase
            // Frame completion overrides the per-state next values (incl. PARITY when disabled).
            if (frame_end) begin
               state   <= HUNT;
               len_reg <= '0;
               len_cnt <= '0;
               bit_cnt <= '0;
               par_acc <= 1'b0;
               done    <= 1'b1;
               err     <= frame_bad;
               if (!frame_bad) cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

   assign bus.SerOut      = ser_out;
   assign bus.SerOutValid = out_valid;
   assign bus.FrameDone   = done;
   assign bus.FrameErr    = err;
   assign bus.CntOut      = cnt;
endmodule

// File: tb/tb_telegraph_frame_rx.sv
// Self-checking bench for telegraph_frame_rx: table vectors, hand sequences, randomized frames.
module tb_telegraph_frame_rx;
   localparam int unsigned FLAG_W = 8;
   localparam logic [7:0]  FLAG   = 8'h7E;
   localparam int unsigned LEN_W  = 4;
   localparam int unsigned CNT_W  = 4;

   typedef struct {
      int unsigned len;
      logic [15:0] payload;
      logic        parbit;
      logic        exp_err;
      logic [3:0]  exp_cnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   logic ser = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [3:0] mcnt = '0;
   logic       last_so = 1'b0;
   logic       seen_err = 1'b0;
   logic [3:0] np_cnt = '0;
   logic       np_so = 1'b0;
   vec_t       tbl[8];

   telegraph_frame_rx_if #(.CNT_W(CNT_W)) bus ();
   telegraph_frame_rx_if #(.CNT_W(CNT_W)) bus_np ();

   assign bus.ClkEn    = en;
   assign bus.SerIn    = ser;
   assign bus_np.ClkEn = en;
   assign bus_np.SerIn = ser;

   telegraph_frame_rx #(
      .FLAG_W(FLAG_W), .FLAG(FLAG), .LEN_W(LEN_W), .PARITY_EN(1'b1), .CNT_W(CNT_W)
   ) dut (.Clk(clk), .Rst(rst), .bus(bus));

   telegraph_frame_rx #(
      .FLAG_W(FLAG_W), .FLAG(FLAG), .LEN_W(LEN_W), .PARITY_EN(1'b0), .CNT_W(CNT_W)
   ) dut_np (.Clk(clk), .Rst(rst), .bus(bus_np));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) begin
         @(negedge clk);
         en  = 1'b0;
         ser = 1'($urandom);
         @(posedge clk);
         #1;
         check("idle_hold", {bus.SerOutValid, bus.SerOut, bus.FrameDone, bus.FrameErr, bus.CntOut},
               {1'b0, last_so, 2'b00, mcnt});
      end
   endtask

   task automatic sample(input logic b, input logic v, input logic d, input logic e,
                         input int unsigned gap, input string name);
      @(negedge clk);
      en  = 1'b1;
      ser = b;
      @(posedge clk);
      #1;
      if (v) last_so = b;
      if (d && !e) mcnt = mcnt + 4'd1;
      check(name, {bus.SerOutValid, bus.SerOut, bus.FrameDone, bus.FrameErr, bus.CntOut},
            {v, last_so, d, e, mcnt});
      seen_err = bus.FrameErr;
      idle(gap);
   endtask

   // True when noise followed by the flag produces a flag window only at the very end.
   function automatic bit noise_ok(input logic [31:0] nz, input int unsigned n);
      logic [7:0] w  = '0;
      logic [7:0] fl = FLAG;
      logic       b;
      for (int unsigned i = 0; i < n + 8; i++) begin
         b = (i < n) ? nz[n-1-i] : fl[7-(i-n)];
         w = {w[6:0], b};
         if (w == fl && i < n + 7) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic int unsigned pick_gap(input bit rand_gap);
      return rand_gap ? $urandom_range(1, 3) : 1;
   endfunction

   task automatic send_frame(input int unsigned len, input logic [15:0] payload, input logic parbit,
                             input int unsigned noise_n, input bit rand_gap, input int gap_at);
      logic [31:0] nz;
      logic [7:0]  fl = FLAG;
      logic [3:0]  lv = len[3:0];
      logic        par = 1'b0;
      logic        b;
      int unsigned tries = 0;
      nz = '0;
      if (noise_n > 0) begin
         do begin
            nz = $urandom;
            tries++;
         end while (!noise_ok(nz, noise_n) && tries < 100);
         if (!noise_ok(nz, noise_n)) nz = '0;
      end
      for (int unsigned i = 0; i < noise_n; i++) sample(nz[noise_n-1-i], 0, 0, 0, pick_gap(rand_gap), "noise");
      for (int i = 0; i < 8; i++) sample(fl[7-i], 0, 0, 0, (i == gap_at) ? 5 : pick_gap(rand_gap), "flag");
      for (int i = 0; i < 4; i++) sample(lv[3-i], 0, 0, 0, pick_gap(rand_gap), "len");
      for (int unsigned i = 0; i < len; i++) begin
         b   = payload[len-1-i];
         par = par ^ b;
         sample(b, 1, 0, 0, pick_gap(rand_gap), "payload");
      end
      sample(parbit, 0, 1, parbit != par, pick_gap(rand_gap), "parity");
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      en  = 1'b0;
      #1;
      check("reset_out", {bus.SerOutValid, bus.SerOut, bus.FrameDone, bus.FrameErr, bus.CntOut}, 32'h0);
      check("reset_out_np", {bus_np.SerOutValid, bus_np.SerOut, bus_np.FrameDone, bus_np.FrameErr, bus_np.CntOut}, 32'h0);
      mcnt    = '0;
      last_so = 1'b0;
      np_cnt  = '0;
      np_so   = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic np_sample(input logic b, input logic v, input logic d, input string name);
      @(negedge clk);
      en  = 1'b1;
      ser = b;
      @(posedge clk);
      #1;
      if (v) np_so = b;
      if (d) np_cnt = np_cnt + 4'd1;
      check(name, {bus_np.SerOutValid, bus_np.SerOut, bus_np.FrameDone, bus_np.FrameErr, bus_np.CntOut},
            {v, np_so, d, 1'b0, np_cnt});
      @(negedge clk);
      en = 1'b0;
      @(posedge clk);
      #1;
      check("np_idle", {bus_np.SerOutValid, bus_np.FrameDone, bus_np.FrameErr, bus_np.CntOut}, {3'b000, np_cnt});
   endtask

   initial begin
      logic [7:0] fl = FLAG;
      logic [3:0] lv;
      tbl[0] = '{3,  16'h0005, 1'b0, 1'b0, 4'd1};
      tbl[1] = '{3,  16'h0005, 1'b1, 1'b1, 4'd1};
      tbl[2] = '{0,  16'h0000, 1'b0, 1'b0, 4'd2};
      tbl[3] = '{0,  16'h0000, 1'b1, 1'b1, 4'd2};
      tbl[4] = '{15, 16'h7E7E, 1'b0, 1'b0, 4'd3};
      tbl[5] = '{1,  16'h0001, 1'b1, 1'b0, 4'd4};
      tbl[6] = '{2,  16'h0003, 1'b1, 1'b1, 4'd4};
      tbl[7] = '{4,  16'h0006, 1'b0, 1'b0, 4'd5};

      repeat (3) @(negedge clk);
      check("reset_init", {bus.SerOutValid, bus.SerOut, bus.FrameDone, bus.FrameErr, bus.CntOut}, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         send_frame(tbl[i].len, tbl[i].payload, tbl[i].parbit, 0, 1'b0, -1);
         check("tbl_err", seen_err, tbl[i].exp_err);
         check("tbl_cnt", bus.CntOut, tbl[i].exp_cnt);
      end

      // noisy prefix plus a long ClkEn gap inside the flag
      send_frame(3, 16'h0005, 1'b0, 6, 1'b0, 6);
      check("gap_cnt", bus.CntOut, 4'd6);

      repeat (40) begin
         send_frame($urandom_range(0, 15), 16'($urandom), 1'($urandom), $urandom_range(0, 12), 1'b1, -1);
      end

      do_reset();
      repeat (15) send_frame(1, 16'h0001, 1'b1, 0, 1'b0, -1);
      check("wrap15", bus.CntOut, 4'd15);
      send_frame(1, 16'h0001, 1'b1, 0, 1'b0, -1);
      check("wrap16", bus.CntOut, 4'd0);

      send_frame(2, 16'h0002, 1'b1, 0, 1'b0, -1);
      for (int i = 0; i < 8; i++) sample(fl[7-i], 0, 0, 0, 1, "mr_flag");
      lv = 4'd3;
      for (int i = 0; i < 4; i++) sample(lv[3-i], 0, 0, 0, 1, "mr_len");
      sample(1'b1, 1, 0, 0, 1, "mr_pay0");
      sample(1'b0, 1, 0, 0, 0, "mr_pay1");
      #2;
      rst = 1'b1;
      #1;
      check("mr_reset", {bus.SerOutValid, bus.SerOut, bus.FrameDone, bus.FrameErr, bus.CntOut}, 32'h0);
      mcnt    = '0;
      last_so = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      send_frame(3, 16'h0005, 1'b0, 0, 1'b0, -1);
      check("mr_after", bus.CntOut, 4'd1);

      do_reset();
      for (int i = 0; i < 8; i++) np_sample(fl[7-i], 0, 0, "np_flag");
      for (int i = 0; i < 3; i++) np_sample(1'b0, 0, 0, "np_len");
      np_sample(1'b0, 0, 1, "np_zero_done");
      for (int i = 0; i < 8; i++) np_sample(fl[7-i], 0, 0, "np_flag2");
      lv = 4'd2;
      for (int i = 0; i < 4; i++) np_sample(lv[3-i], 0, 0, "np_len2");
      np_sample(1'b1, 1, 0, "np_pay0");
      np_sample(1'b0, 1, 1, "np_pay1_done");
      check("np_cnt", bus_np.CntOut, 4'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/telegraph_frame_rx.md
Name: telegraph_frame_rx

Overview:
Parametrised serial telegraph frame receiver. It is the next generation of the OthFSMmini serial FSM. The block hunts the ClkEn-qualified SerIn stream for a configurable start flag, then reads a length field. It forwards the payload bits on SerOut/SerOutValid, optionally checks an even-parity bit, and counts good frames. It sits between the bit-rate enable generator and the telegraph payload consumer.

Parameters:
FLAG_W, 8, start-flag width in bits (2..16)
FLAG, 8'h7E, start-flag pattern, MSB received first; must not be all zeros
LEN_W, 4, width of the length field; payload length N ranges 0..2^LEN_W-1
PARITY_EN, 1, 1 = an even-parity bit follows the payload; 0 = no parity bit
CNT_W, 4, width of the good-frame counter

Ports:
Clk  in  1  system clock; all state changes on its rising edge
Rst  in  1  asynchronous, active-high reset
ClkEn  in  1  bit-sample enable; SerIn is sampled only on edges where ClkEn=1
SerIn  in  1  serial line, MSB first
SerOut  out  1  registered payload bit
SerOutValid  out  1  one-cycle pulse marking a valid SerOut
FrameDone  out  1  one-cycle pulse at the end of every frame, good or bad
FrameErr  out  1  one-cycle pulse, coincident with FrameDone, on parity mismatch
CntOut  out  CNT_W  good-frame counter; wraps 2^CNT_W-1 -> 0

Behaviour:
- Reset (asynchronous, takes effect mid-frame too):
  - state=HUNT; flag window=0; length/bit counters=0; parity accumulator=0.
  - SerOut=0, SerOutValid=0, FrameDone=0, FrameErr=0, CntOut=0.
- Sampling: "sample" means a Clk rising edge with ClkEn=1.
  - With ClkEn=0, all state and counters hold.
  - Pulse outputs (SerOutValid, FrameDone, FrameErr) are high for exactly one Clk cycle, then drop regardless of ClkEn.
- HUNT:
  - On each sample, window <= {window[FLAG_W-2:0], SerIn}.
  - When the new window equals FLAG, go to LEN and clear the window to 0.
  - Overlapping flags are not searched for after a match.
- LEN:
  - Shift LEN_W samples MSB-first into the length register.
  - On the last length sample:
    - N>0: go to PAYLOAD.
    - N=0 and PARITY_EN=1: go to PARITY.
    - N=0 and PARITY_EN=0: go to END.
- PAYLOAD:
  - Each sample: SerOut <= SerIn; SerOutValid <= 1; parity accumulator ^= SerIn; bit count increments.
  - Latency: the bit sampled at edge k is visible on SerOut with SerOutValid=1 in the cycle after edge k.
  - After N samples: go to PARITY if PARITY_EN=1, else to END.
- PARITY:
  - One sample. FrameErr is set iff SerIn != parity accumulator.
  - Continue to END at that same edge.
- END is not a waiting state; frame completion is registered at the final sample edge:
  - FrameDone <= 1.
  - FrameErr as computed in PARITY (always 0 when PARITY_EN=0).
  - CntOut <= CntOut+1 only when there is no error.
  - State returns to HUNT; window=0; counters and accumulator cleared.
- Boundaries:
  - N=0 with PARITY_EN=1: the parity bit must be 0.
  - N=2^LEN_W-1 payload bits are supported.
  - CntOut wraps with no flag.
  - A flag pattern appearing inside a payload is treated as data.
  - Reset asserted mid-payload drops the partial frame: no FrameDone, no CntOut change.
- SerOut holds its last value when SerOutValid=0.

Decomposition:
- Package telegraph_pkg:
  - state enum rx_state_t {HUNT, LEN, PAYLOAD, PARITY}.
  - Default FLAG constant.
  - Parameter-legality checks (FLAG != 0, FLAG_W >= 2).
- Sub-module telegraph_flag_det:
  - Parameters FLAG_W and FLAG.
  - Inputs Clk, Rst, ClkEn, SerIn, clr.
  - Output match (combinational compare of the next window).
  - telegraph_frame_rx instantiates it once and drives clr on match or frame end.

Test Plan:
All scenarios use defaults unless stated; ClkEn is 1 on every other Clk edge.

1. Good frame: bits 01111110, 0011, 1,0,1, parity 0 -> SerOutValid pulses 3 times with SerOut 1,0,1; one FrameDone, FrameErr=0; CntOut 0->1.
2. Parity error: same frame with parity bit 1 -> 3 data pulses; FrameDone and FrameErr together; CntOut stays 0.
3. Zero length: flag, 0000, parity 0 -> no SerOutValid; FrameDone; CntOut=1. Repeat with PARITY_EN=0: FrameDone on the last length bit, no parity bit consumed.
4. Noise plus ClkEn gaps: 0111111 0 with ClkEn held low for 5 cycles mid-flag, then a valid frame -> flag still recognised; outputs identical to scenario 1.
5. Wrap: 16 consecutive good frames -> CntOut reads 15 after frame 15, then 0 after frame 16.
6. Reset mid-payload: assert Rst after the 2nd of 3 payload bits -> all outputs 0 immediately; the following full frame is received correctly with CntOut=1.
